// File: rtl/dbus_responder.sv
// dbus_responder: single-port 64-bit data memory behind a fixed-latency
// request/response handshake (IDLE -> WAIT x LATENCY -> RESP -> IDLE).
module dbus_responder #(
   parameter int unsigned DEPTH   = 512,
   parameter int unsigned LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        dreq_valid,
   input  logic [63:0] dreq_addr,
   input  logic [2:0]  dreq_size,
   input  logic [7:0]  dreq_strobe,
   input  logic [63:0] dreq_data,
   output logic        dresp_addr_ok,
   output logic        dresp_data_ok,
   output logic [63:0] dresp_data,
   output logic        busy
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = 4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t          r_state;
   logic [CW-1:0]   r_cnt;
   logic [63:0]     r_addr;
   logic [2:0]      r_size;
   logic [7:0]      r_strobe;
   logic [63:0]     r_data;
   logic            r_addr_ok;
   logic            r_data_ok;
   logic [63:0]     r_dresp_data;
   logic            r_busy;

   // Word storage; intentionally not reset.
   logic [63:0]     r_mem [DEPTH];

   logic [AW-1:0]   w_index;
   logic            w_unused;

   // Word index from the latched address; byte offset and upper bits wrap away.
   assign w_index  = r_addr[AW+2:3];

   // Size and the discarded address bits are kept only as latched state.
   assign w_unused = ^{r_size, r_addr[63:AW+3], r_addr[2:0]};

   // Request FSM: accept, count down the wait, present one response cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_addr       <= '0;
         r_size       <= '0;
         r_strobe     <= '0;
         r_data       <= '0;
         r_addr_ok    <= 1'b0;
         r_data_ok    <= 1'b0;
         r_dresp_data <= '0;
         r_busy       <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (dreq_valid) begin
                  r_addr   <= dreq_addr;
                  r_size   <= dreq_size;
                  r_strobe <= dreq_strobe;
                  r_data   <= dreq_data;
                  r_cnt    <= CW'(LATENCY - 1);
                  r_busy   <= 1'b1;
                  r_state  <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (r_cnt != {CW{1'b0}}) begin
                  r_cnt <= r_cnt - CW'(1);
               end else begin
                  // Old word is returned for reads and writes alike.
                  r_dresp_data <= r_mem[w_index];
                  r_addr_ok    <= 1'b1;
                  r_data_ok    <= 1'b1;
                  r_state      <= S_RESP;
               end
            end
            S_RESP: begin
               r_addr_ok <= 1'b0;
               r_data_ok <= 1'b0;
               r_busy    <= 1'b0;
               r_state   <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Byte-masked write commit on the RESP->IDLE edge; reset forces IDLE so
   // an interrupted request never commits.
   always_ff @(posedge clk) begin
      if (r_state == S_RESP) begin
         for (int i = 0; i < 8; i++) begin
            if (r_strobe[i]) begin
               r_mem[w_index][8*i +: 8] <= r_data[8*i +: 8];
            end
         end
      end
   end

   assign dresp_addr_ok = r_addr_ok;
   assign dresp_data_ok = r_data_ok;
   assign dresp_data    = r_dresp_data;
   assign busy          = r_busy;

endmodule

// File: tb/tb_dbus_responder.sv
// Bench for dbus_responder: directed vector table, randomized traffic against a
// word-array model, back-to-back, mid-request reset and a LATENCY=1 instance.
module tb_dbus_responder;

   localparam int unsigned DEPTH0 = 512;
   localparam int unsigned LAT0   = 2;
   localparam int unsigned DEPTH1 = 16;

   logic        clk;
   logic        reset;

   logic        dreq_valid;
   logic [63:0] dreq_addr;
   logic [2:0]  dreq_size;
   logic [7:0]  dreq_strobe;
   logic [63:0] dreq_data;
   logic        dresp_addr_ok;
   logic        dresp_data_ok;
   logic [63:0] dresp_data;
   logic        busy;

   logic        d1_valid;
   logic [63:0] d1_addr;
   logic [2:0]  d1_size;
   logic [7:0]  d1_strobe;
   logic [63:0] d1_data;
   logic        d1_addr_ok;
   logic        d1_data_ok;
   logic [63:0] d1_rdata;
   logic        d1_busy;

   int          n_chk;
   int          n_fail;

   logic [63:0] model_mem [DEPTH0];

   typedef struct {
      logic [63:0] addr;
      logic [7:0]  strb;
      logic [63:0] data;
      logic [63:0] exp;
   } vec_t;

   vec_t vecs [10];

   dbus_responder #(.DEPTH(DEPTH0), .LATENCY(LAT0)) u_dut (
      .clk           (clk),
      .reset         (reset),
      .dreq_valid    (dreq_valid),
      .dreq_addr     (dreq_addr),
      .dreq_size     (dreq_size),
      .dreq_strobe   (dreq_strobe),
      .dreq_data     (dreq_data),
      .dresp_addr_ok (dresp_addr_ok),
      .dresp_data_ok (dresp_data_ok),
      .dresp_data    (dresp_data),
      .busy          (busy)
   );

   dbus_responder #(.DEPTH(DEPTH1), .LATENCY(1)) u_dut1 (
      .clk           (clk),
      .reset         (reset),
      .dreq_valid    (d1_valid),
      .dreq_addr     (d1_addr),
      .dreq_size     (d1_size),
      .dreq_strobe   (d1_strobe),
      .dreq_data     (d1_data),
      .dresp_addr_ok (d1_addr_ok),
      .dresp_data_ok (d1_data_ok),
      .dresp_data    (d1_rdata),
      .busy          (d1_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Model: word index is byte address / 8, wrapped modulo DEPTH.
   function automatic int unsigned widx(input logic [63:0] a);
      return 32'((a / 64'd8) % 64'(DEPTH0));
   endfunction

   function automatic logic [63:0] merge(input logic [63:0] old, input logic [7:0] s,
                                         input logic [63:0] d);
      logic [63:0] w;
      w = old;
      for (int b = 0; b < 8; b++) begin
         if (s[b]) w[8*b +: 8] = d[8*b +: 8];
      end
      return w;
   endfunction

   task automatic drive_rand(input logic v);
      dreq_valid  = v;
      dreq_addr   = {$urandom(), $urandom()};
      dreq_size   = 3'($urandom());
      dreq_strobe = 8'($urandom());
      dreq_data   = {$urandom(), $urandom()};
   endtask

   // Called just after a negedge in an IDLE cycle; returns at the negedge of
   // the IDLE cycle that follows RESP.
   task automatic run_req(input string nm, input logic [63:0] a, input logic [7:0] s,
                          input logic [63:0] d, input logic [63:0] exp);
      chk({nm, " busy before accept"}, 64'(busy), 64'd0);
      dreq_valid  = 1'b1;
      dreq_addr   = a;
      dreq_size   = 3'($urandom());
      dreq_strobe = s;
      dreq_data   = d;
      @(posedge clk);
      for (int k = 1; k <= int'(LAT0) + 1; k++) begin
         @(negedge clk);
         chk({nm, " busy"}, 64'(busy), 64'd1);
         chk({nm, " addr_ok"}, 64'(dresp_addr_ok), 64'(k == int'(LAT0) + 1));
         chk({nm, " data_ok"}, 64'(dresp_data_ok), 64'(k == int'(LAT0) + 1));
         if (k == int'(LAT0) + 1) chk({nm, " data"}, dresp_data, exp);
         drive_rand(1'b0);
      end
      if (s != 8'd0) model_mem[widx(a)] = merge(model_mem[widx(a)], s, d);
      @(negedge clk);
      chk({nm, " idle busy"}, 64'(busy), 64'd0);
      chk({nm, " idle data_ok"}, 64'(dresp_data_ok), 64'd0);
      chk({nm, " held data"}, dresp_data, exp);
   endtask

   initial begin
      logic [63:0] a;
      logic [63:0] a2;
      logic [7:0]  s;
      logic [63:0] d;
      logic [63:0] v1;
      logic [63:0] w1;

      n_chk  = 0;
      n_fail = 0;
      for (int i = 0; i < int'(DEPTH0); i++) model_mem[i] = 64'd0;

      vecs[0] = '{64'h40,                  8'hFF, 64'h1122334455667788, 64'h0};
      vecs[1] = '{64'h40,                  8'h00, 64'h0,                64'h1122334455667788};
      vecs[2] = '{64'h8,                   8'hFF, 64'hFFFFFFFF00000000, 64'h0};
      vecs[3] = '{64'h8,                   8'h0F, 64'hAAAAAAAADEADBEEF, 64'hFFFFFFFF00000000};
      vecs[4] = '{64'h8,                   8'h00, 64'h0,                64'hFFFFFFFFDEADBEEF};
      vecs[5] = '{64'h1000,                8'h01, 64'h000000000000005A, 64'h0};
      vecs[6] = '{64'h0,                   8'h00, 64'h0,                64'h000000000000005A};
      vecs[7] = '{64'h1003,                8'h00, 64'h0,                64'h000000000000005A};
      vecs[8] = '{64'h47,                  8'h80, 64'hCC00000000000000, 64'h1122334455667788};
      vecs[9] = '{64'hFFFFFFFFFFFFF040,    8'h00, 64'h0,                64'hCC22334455667788};

      reset = 1'b0;
      drive_rand(1'b0);
      d1_valid = 1'b0; d1_addr = '0; d1_size = '0; d1_strobe = '0; d1_data = '0;
      repeat (3) @(negedge clk);
      chk("reset busy", 64'(busy), 64'd0);
      chk("reset addr_ok", 64'(dresp_addr_ok), 64'd0);
      chk("reset data_ok", 64'(dresp_data_ok), 64'd0);
      chk("reset data", dresp_data, 64'd0);
      reset = 1'b1;
      @(negedge clk);
      chk("post-reset busy", 64'(busy), 64'd0);

      // Directed vectors
      for (int i = 0; i < 10; i++) begin
         run_req($sformatf("vec%0d", i), vecs[i].addr, vecs[i].strb, vecs[i].data, vecs[i].exp);
      end

      // Randomized traffic against the model
      for (int i = 0; i < 200; i++) begin
         a = {$urandom(), $urandom()};
         a[11:3] = 9'($urandom_range(0, 15));
         if ($urandom_range(0, 7) == 0) a[11:3] = 9'd511;
         s = ($urandom_range(0, 1) == 1) ? 8'($urandom()) : 8'd0;
         d = {$urandom(), $urandom()};
         run_req($sformatf("rnd%0d", i), a, s, d, model_mem[widx(a)]);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      // Back-to-back reads with valid held and inputs changing during WAIT
      v1 = 64'h0123456789ABCDEF;
      run_req("b2b setup", 64'h320, 8'hFF, v1, model_mem[widx(64'h320)]);
      a  = 64'h40;
      a2 = 64'h320;
      for (int k = 0; k < 10; k++) begin
         chk($sformatf("b2b data_ok k%0d", k), 64'(dresp_data_ok), 64'(k == 3 || k == 7));
         chk($sformatf("b2b busy k%0d", k), 64'(busy),
             64'(!(k == 0 || k == 4 || k == 8 || k == 9)));
         if (k == 3) chk("b2b data1", dresp_data, model_mem[widx(a)]);
         if (k == 7) chk("b2b data2", dresp_data, model_mem[widx(a2)]);
         if (k == 0) begin
            dreq_valid = 1'b1; dreq_addr = a; dreq_strobe = 8'h00; dreq_data = '0;
         end else if (k == 4) begin
            dreq_valid = 1'b1; dreq_addr = a2; dreq_strobe = 8'h00; dreq_data = '0;
         end else begin
            drive_rand(k < 4);
         end
         @(negedge clk);
      end

      // Reset during WAIT of a full write
      run_req("rst-wait prime", 64'h320, 8'h00, 64'h0, v1);
      w1 = 64'hDEADDEADDEADDEAD;
      dreq_valid = 1'b1; dreq_addr = 64'h320; dreq_strobe = 8'hFF; dreq_data = w1;
      @(posedge clk);
      @(negedge clk);
      drive_rand(1'b0);
      chk("rst-wait busy before", 64'(busy), 64'd1);
      reset = 1'b0;
      #1;
      chk("rst-wait busy", 64'(busy), 64'd0);
      chk("rst-wait addr_ok", 64'(dresp_addr_ok), 64'd0);
      chk("rst-wait data_ok", 64'(dresp_data_ok), 64'd0);
      chk("rst-wait data", dresp_data, 64'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      run_req("rst-wait readback", 64'h320, 8'h00, 64'h0, v1);

      // Reset during RESP of a full write
      dreq_valid = 1'b1; dreq_addr = 64'h320; dreq_strobe = 8'hFF; dreq_data = w1;
      @(posedge clk);
      for (int k = 1; k <= int'(LAT0) + 1; k++) begin
         @(negedge clk);
         drive_rand(1'b0);
      end
      chk("rst-resp data_ok before", 64'(dresp_data_ok), 64'd1);
      reset = 1'b0;
      #1;
      chk("rst-resp data_ok", 64'(dresp_data_ok), 64'd0);
      chk("rst-resp busy", 64'(busy), 64'd0);
      chk("rst-resp data", dresp_data, 64'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      run_req("rst-resp readback", 64'h320, 8'h00, 64'h0, v1);

      // LATENCY=1 instance: write then wrapped read
      d = 64'hA5A5_0F0F_1234_5678;
      chk("lat1 busy idle", 64'(d1_busy), 64'd0);
      d1_valid = 1'b1; d1_addr = 64'h18; d1_strobe = 8'hFF; d1_data = d;
      @(negedge clk);
      d1_valid = 1'b0; d1_addr = 64'hFFFF; d1_strobe = 8'hFF; d1_data = '1;
      chk("lat1 C+1 busy", 64'(d1_busy), 64'd1);
      chk("lat1 C+1 data_ok", 64'(d1_data_ok), 64'd0);
      chk("lat1 C+1 addr_ok", 64'(d1_addr_ok), 64'd0);
      @(negedge clk);
      chk("lat1 C+2 data_ok", 64'(d1_data_ok), 64'd1);
      chk("lat1 C+2 addr_ok", 64'(d1_addr_ok), 64'd1);
      chk("lat1 C+2 data", d1_rdata, 64'd0);
      @(negedge clk);
      chk("lat1 C+3 data_ok", 64'(d1_data_ok), 64'd0);
      chk("lat1 C+3 busy", 64'(d1_busy), 64'd0);
      d1_valid = 1'b1; d1_addr = 64'h98; d1_strobe = 8'h00; d1_data = '0;
      @(negedge clk);
      d1_valid = 1'b0;
      chk("lat1 rd C+1 data_ok", 64'(d1_data_ok), 64'd0);
      @(negedge clk);
      chk("lat1 rd C+2 data_ok", 64'(d1_data_ok), 64'd1);
      chk("lat1 rd C+2 data", d1_rdata, d);
      @(negedge clk);
      chk("lat1 rd C+3 data_ok", 64'(d1_data_ok), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/dbus_responder.md
DBUS_RESPONDER -- requirements
Module: dbus_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 512, meaning the number of 64-bit memory words; it SHALL be a power of two and at least 2.
REQ-002 The block SHALL have parameter LATENCY, default 2, meaning the number of WAIT cycles between accept and response; legal range is 1..15.
REQ-003 clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; the block is held in reset while reset=0.
REQ-005 dreq_valid  input  1  request present from the memory stage.
REQ-006 dreq_addr  input  64  byte address of the request.
REQ-007 dreq_size  input  3  access size code; latched only, no functional effect.
REQ-008 dreq_strobe  input  8  byte-write enables; 0 means a read.
REQ-009 dreq_data  input  64  write data, byte lanes aligned to the strobe.
REQ-010 dresp_addr_ok  output  1  address phase accepted.
REQ-011 dresp_data_ok  output  1  data phase complete.
REQ-012 dresp_data  output  64  read data; word at the latched address.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, WAIT and RESP.
REQ-015 In IDLE with dreq_valid=1, the rising edge SHALL latch addr, size, strobe and data, load cnt=LATENCY-1, and move the FSM to WAIT.
REQ-016 In IDLE with dreq_valid=0, the FSM SHALL remain in IDLE with no state change.
REQ-017 In WAIT with cnt!=0, each edge SHALL decrement cnt; in WAIT with cnt=0, the next edge SHALL move the FSM to RESP.
REQ-018 Latency: for a request accepted from cycle C, dresp_addr_ok and dresp_data_ok SHALL both be 1 in exactly cycle C+1+LATENCY, and 0 in all other cycles.
REQ-019 RESP SHALL last exactly one cycle, and the next state SHALL be IDLE unconditionally.
REQ-020 dreq_valid seen in the IDLE cycle after RESP SHALL be treated as a new request, so back-to-back requests are separated by exactly one IDLE cycle.
REQ-021 dreq_* inputs SHALL be ignored in WAIT and RESP; only the latched copy is used.
REQ-022 Word index SHALL be addr[log2(DEPTH)+2:3]; upper address bits are ignored, so the address wraps modulo DEPTH*8; addr[2:0] is ignored.
REQ-023 On a read (latched strobe=0), dresp_data SHALL be registered from mem[index] on the WAIT->RESP edge and valid during RESP.
REQ-024 On a read, memory SHALL not be modified.
REQ-025 On a write (strobe!=0), for each i with strobe[i]=1, the RESP->IDLE edge SHALL update byte i of mem[index] to data[8i+7:8i]; other bytes SHALL be unchanged.
REQ-026 On a write, dresp_data during RESP SHALL be the pre-write word.
REQ-027 A read issued after a write completes SHALL observe the written bytes, with no forwarding hazard.
REQ-028 dresp_data SHALL hold its last value outside RESP; consumers qualify it with dresp_data_ok.
REQ-029 The size field SHALL be latched but SHALL have no functional effect; the full 64-bit word is always returned.
REQ-030 Memory SHALL be a synchronous single-port array; one access per request.

Reset
REQ-031 While reset=0, the block SHALL asynchronously force: state=IDLE, cnt=0, dresp_addr_ok=0, dresp_data_ok=0, dresp_data=0, busy=0, and latched request fields=0.
REQ-032 Memory contents SHALL not be reset; the simulation initial value is 0.
REQ-033 If reset asserts during WAIT or RESP, the in-flight request SHALL be dropped and any pending write SHALL not be committed.
REQ-034 After reset deasserts, the first edge in IDLE with dreq_valid=1 SHALL accept a new request.

Verification
REQ-035 Read latency, LATENCY=2: valid read at addr 0x40 in cycle 10 with mem[8]=0x1122334455667788 -> addr_ok=data_ok=1 only in cycle 13 with dresp_data=0x1122334455667788, and busy=1 in cycles 11-13.
REQ-036 Partial write: write addr 0x8 with strobe=0x0F and data=0xAAAAAAAA_DEADBEEF over old word 0xFFFFFFFF_00000000, then read 0x8 -> read returns 0xFFFFFFFF_DEADBEEF.
REQ-037 Wrap-around, DEPTH=512: write 0x5A at addr 0x1000 (index 0), then read addr 0x0 -> read returns the byte-0 lane = 0x5A.
REQ-038 Back-to-back: dreq_valid held at 1 for two reads -> data_ok pulses in cycles C+3 and C+7 with one IDLE cycle between, and inputs changed during WAIT are ignored.
REQ-039 Reset mid-write: reset=0 during the WAIT of a strobe=0xFF write -> outputs go to 0 immediately, and a subsequent read of that word returns the old value.
REQ-040 LATENCY=1 edge case: accept in cycle C -> data_ok in cycle C+2, and no pulse in cycle C+1.
